// File: rtl/pos_mask_builder.sv
// Accumulates a stream of bit-position indices into a bitmask and presents it with its popcount.
// Optional duplicate-index reporting (out_dup) is enabled by defining POS_MASK_DUP_EN.
module pos_mask_builder #(
  parameter int WIDTH = 8,
  parameter int POS_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [CNT_W-1:0] out_count,
  output logic             out_oor
`ifdef POS_MASK_DUP_EN
  ,
  output logic             out_dup
`endif
);

  typedef enum logic {ACCUM, HOLD} state_t;

  function automatic logic pos_in_range(input logic [POS_W-1:0] p);
    return 32'(p) < WIDTH;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_p0, acc_d;
  logic             oor_p0, oor_d;
  logic             vld_p1, vld_d;
  logic [WIDTH-1:0] mask_p1, mask_d;
  logic [CNT_W-1:0] cnt_p1, cnt_d;
  logic             oor_p1, oor1_d;
`ifdef POS_MASK_DUP_EN
  logic             dup_p0, dup_d;
  logic             dup_p1, dup1_d;
  logic             dup_new;
`endif

  logic             beat;
  logic             inr;
  logic [WIDTH-1:0] onehot;
  logic [WIDTH-1:0] acc_new;
  logic             oor_new;

  assign in_ready = (state_q == ACCUM) ? 1'b1 : out_ready;
  assign beat     = in_valid & in_ready;
  assign inr      = pos_in_range(in_pos);
  // Out-of-range shifts fall off the top, so onehot is zero for them.
  assign onehot   = WIDTH'(1) << in_pos;
  assign acc_new  = acc_p0 | onehot;
  assign oor_new  = oor_p0 | ~inr;
`ifdef POS_MASK_DUP_EN
  assign dup_new  = dup_p0 | (inr & |(acc_p0 & onehot));
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_p0;
    oor_d   = oor_p0;
    vld_d   = vld_p1;
    mask_d  = mask_p1;
    cnt_d   = cnt_p1;
    oor1_d  = oor_p1;
`ifdef POS_MASK_DUP_EN
    dup_d   = dup_p0;
    dup1_d  = dup_p1;
`endif
    // In HOLD acc_p0 is always zero, so a beat there naturally starts a fresh frame.
    if (beat) begin
      if (in_last) begin
        mask_d  = acc_new;
        cnt_d   = popcount(acc_new);
        oor1_d  = oor_new;
        vld_d   = 1'b1;
        acc_d   = '0;
        oor_d   = 1'b0;
        state_d = HOLD;
`ifdef POS_MASK_DUP_EN
        dup1_d  = dup_new;
        dup_d   = 1'b0;
`endif
      end else begin
        acc_d   = acc_new;
        oor_d   = oor_new;
        vld_d   = 1'b0;
        state_d = ACCUM;
`ifdef POS_MASK_DUP_EN
        dup_d   = dup_new;
`endif
      end
    end else if (state_q == HOLD && out_ready) begin
      vld_d   = 1'b0;
      state_d = ACCUM;
    end
  end

  // Stage boundary: frame accumulator (p0) and presented result (p1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_p0  <= '0;
      oor_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      mask_p1 <= '0;
      cnt_p1  <= '0;
      oor_p1  <= 1'b0;
`ifdef POS_MASK_DUP_EN
      dup_p0  <= 1'b0;
      dup_p1  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_p0  <= acc_d;
      oor_p0  <= oor_d;
      vld_p1  <= vld_d;
      mask_p1 <= mask_d;
      cnt_p1  <= cnt_d;
      oor_p1  <= oor1_d;
`ifdef POS_MASK_DUP_EN
      dup_p0  <= dup_d;
      dup_p1  <= dup1_d;
`endif
    end
  end

  assign out_valid = vld_p1;
  assign out_mask  = mask_p1;
  assign out_count = cnt_p1;
  assign out_oor   = oor_p1;
`ifdef POS_MASK_DUP_EN
  assign out_dup   = dup_p1;
`endif

endmodule

// File: tb/tb_pos_mask_builder.sv
// Directed bench for pos_mask_builder: an 8-bit instance and a 6-bit instance (out-of-range indices).
module tb_pos_mask_builder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b0;
  logic [2:0] a_in_pos = '0;
  logic       a_in_ready, a_out_valid, a_out_oor;
  logic [7:0] a_out_mask;
  logic [3:0] a_out_count;
`ifdef POS_MASK_DUP_EN
  logic       a_out_dup;
`endif

  // WIDTH=6 instance
  logic       b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
  logic [2:0] b_in_pos = '0;
  logic       b_in_ready, b_out_valid, b_out_oor;
  logic [5:0] b_out_mask;
  logic [2:0] b_out_count;
`ifdef POS_MASK_DUP_EN
  logic       b_out_dup;
`endif

  pos_mask_builder #(.WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pos(a_in_pos), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mask(a_out_mask),
    .out_count(a_out_count), .out_oor(a_out_oor)
`ifdef POS_MASK_DUP_EN
    , .out_dup(a_out_dup)
`endif
  );

  pos_mask_builder #(.WIDTH(6)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pos(b_in_pos), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mask(b_out_mask),
    .out_count(b_out_count), .out_oor(b_out_oor)
`ifdef POS_MASK_DUP_EN
    , .out_dup(b_out_dup)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [2:0] p, input logic l);
    a_in_valid = 1'b1;
    a_in_pos   = p;
    a_in_last  = l;
  endtask

  task automatic b_beat(input logic [2:0] p, input logic l);
    b_in_valid = 1'b1;
    b_in_pos   = p;
    b_in_last  = l;
  endtask

  initial begin
    // Reset asserted mid-cycle takes effect immediately
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_mask", 32'(a_out_mask), 32'h00);
    chk("rst_out_count", 32'(a_out_count), 32'd0);
    chk("rst_out_oor", 32'(a_out_oor), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);

    // Frame 0,3,7(last) with out_ready=1
    a_out_ready = 1'b1;
    a_beat(3'd0, 1'b0); step();
    chk("f1_vld_mid", 32'(a_out_valid), 32'd0);
    a_beat(3'd3, 1'b0); step();
    a_beat(3'd7, 1'b1); step();
    a_in_valid = 1'b0;
    chk("f1_vld", 32'(a_out_valid), 32'd1);
    chk("f1_mask", 32'(a_out_mask), 32'h89);
    chk("f1_count", 32'(a_out_count), 32'd3);
    chk("f1_oor", 32'(a_out_oor), 32'd0);
`ifdef POS_MASK_DUP_EN
    chk("f1_dup", 32'(a_out_dup), 32'd0);
`endif
    step();
    chk("f1_vld_pulse", 32'(a_out_valid), 32'd0);

    // Frame 1(last) stalled by out_ready=0; competing beat must be ignored
    a_out_ready = 1'b0;
    a_beat(3'd1, 1'b1); step();
    a_beat(3'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("f2_hold_vld", 32'(a_out_valid), 32'd1);
      chk("f2_hold_mask", 32'(a_out_mask), 32'h02);
      chk("f2_hold_count", 32'(a_out_count), 32'd1);
      chk("f2_in_ready", 32'(a_in_ready), 32'd0);
      step();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    #1;
    chk("f2_in_ready_comb", 32'(a_in_ready), 32'd1);
    step();
    chk("f2_vld_after", 32'(a_out_valid), 32'd0);
    chk("f2_mask_after", 32'(a_out_mask), 32'h02);
    step();
    chk("f2_no_dup_beat", 32'(a_out_valid), 32'd0);

    // Back-to-back single-beat frames 5 then 6
    a_beat(3'd5, 1'b1); step();
    chk("b2b_vld0", 32'(a_out_valid), 32'd1);
    chk("b2b_mask0", 32'(a_out_mask), 32'h20);
    a_beat(3'd6, 1'b1); step();
    chk("b2b_vld1", 32'(a_out_valid), 32'd1);
    chk("b2b_mask1", 32'(a_out_mask), 32'h40);
    chk("b2b_count1", 32'(a_out_count), 32'd1);

    // From HOLD, start a multi-beat frame 1,2(last)
    a_beat(3'd1, 1'b0); step();
    chk("hold_restart_vld", 32'(a_out_valid), 32'd0);
    a_beat(3'd2, 1'b1); step();
    a_in_valid = 1'b0;
    chk("hold_restart_mask", 32'(a_out_mask), 32'h06);
    chk("hold_restart_count", 32'(a_out_count), 32'd2);
    step();
    chk("hold_restart_drop", 32'(a_out_valid), 32'd0);

    // WIDTH=6: out-of-range index sets the sticky oor flag
    b_out_ready = 1'b1;
    b_beat(3'd2, 1'b0); step();
    b_beat(3'd7, 1'b1); step();
    chk("oor_mask", 32'(b_out_mask), 32'h04);
    chk("oor_count", 32'(b_out_count), 32'd1);
    chk("oor_flag", 32'(b_out_oor), 32'd1);
    b_beat(3'd0, 1'b1); step();
    chk("oor_clear_mask", 32'(b_out_mask), 32'h01);
    chk("oor_clear_flag", 32'(b_out_oor), 32'd0);
    b_beat(3'd6, 1'b1); step();
    b_in_valid = 1'b0;
    chk("oor_only_mask", 32'(b_out_mask), 32'h00);
    chk("oor_only_count", 32'(b_out_count), 32'd0);
    chk("oor_only_flag", 32'(b_out_oor), 32'd1);
    chk("oor_only_vld", 32'(b_out_valid), 32'd1);
    step();

    // Repeated index counts once (and flags dup when enabled)
    a_beat(3'd2, 1'b0); step();
    a_beat(3'd2, 1'b1); step();
    a_in_valid = 1'b0;
    chk("dup_mask", 32'(a_out_mask), 32'h04);
    chk("dup_count", 32'(a_out_count), 32'd1);
`ifdef POS_MASK_DUP_EN
    chk("dup_flag", 32'(a_out_dup), 32'd1);
`endif
    step();

    // Reset mid-frame discards the partial accumulator and held result
    a_beat(3'd1, 1'b0); step();
    a_beat(3'd4, 1'b0); step();
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(a_out_valid), 32'd0);
    chk("midrst_mask", 32'(a_out_mask), 32'h00);
    #2 rst_n = 1'b1;
    step();
    a_beat(3'd6, 1'b1); step();
    a_in_valid = 1'b0;
    chk("postrst_vld", 32'(a_out_valid), 32'd1);
    chk("postrst_mask", 32'(a_out_mask), 32'h40);
    chk("postrst_count", 32'(a_out_count), 32'd1);
`ifdef POS_MASK_DUP_EN
    chk("postrst_dup", 32'(a_out_dup), 32'd0);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
